iadder_b16_6b_corrector: RTL and testbench
==========================================

Name: iadder_b16_6b_corrector

Overview:
- Variable-latency exact-recovery unit for the 16-bit segmented approximate adder (6-bit windows, stride 3, carry speculated from the A bit three positions below each window).
- Reproduces the approximate sum bit-for-bit, detects which segments mispredicted their carry-in, then repairs one segment per cycle until the result is exact.
- Sits downstream of approximate datapaths wherever an exact result is needed on demand; uses a valid/ready handshake on both sides.

Parameters:
- CNT_W, 3, width of the corr_cnt output. Must be ≥3 so it can hold the maximum of 4 corrections.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept operands
- A  input  16  operand A
- B  input  16  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- SUM  output  17  exact sum A+B
- approx_sum  output  17  original approximate sum, captured before correction
- corr_cnt  output  CNT_W  number of segments repaired
- err_seen  output  1  at least one segment mispredicted

Behaviour:
- Reset: asynchronous assert when rst=0. State=IDLE; in_ready=1; out_valid=0; SUM, approx_sum, corr_cnt, err_seen=0. Reset mid-operation drops the operation; no output is produced for it.
- Approximate formula, fixed:
  - bits[5:0] = (A[5:0]+B[5:0])[5:0].
  - For k=1..3: bits[3k+5:3k+3] = (A[3k+5:3k]+B[3k+5:3k]+A[3k-3])[5:3].
  - bits[16:15] = (A[15:12]+B[15:12]+A[9])[4:3].
- Segment k (k=1..4) occupies bits starting at 3k+3. Segment 4 is 2 bits wide (16:15).
- Error rules, for segment k:
  - predicted carry pc[k] = bit3 of (A[3k+2:3k]+B[3k+2:3k]+A[3k-3]).
  - true carry tc[k] = carry into bit 3k+3 of the exact A+B.
  - err[k] = pc[k]^tc[k].
- Errors depend only on the operands, so repairing one segment never changes another segment's error.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch A and B → APPROX.
  - APPROX (1 cycle): register approx_sum; copy it into SUM; register err[4:1]; err_seen=|err; corr_cnt=0. If err==0 → DONE, else → CORRECT.
  - CORRECT: each cycle, take the lowest set err[k]. Overwrite that segment's SUM bits with the exact bits of A+B, clear err[k], and increment corr_cnt. When the last bit clears → DONE.
  - DONE: out_valid=1; outputs held stable. On out_ready → IDLE with out_valid=0 on the next edge.
- Latency, accept edge to out_valid: 2 + popcount(err). Range is 2..6 cycles.
- in_ready is high only in IDLE. There is no overlap of operations. A new operand can be accepted at the earliest one cycle after the output handshake.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Arithmetic is unsigned. SUM[16] is the exact carry-out. The final SUM always equals A+B.

Optional Feature:
- Macro: IADDER_ERR_STATS_EN.
- When defined, the block adds:
  - output err_ops[15:0]: counts completed operations with err_seen=1, saturating at 16'hFFFF.
  - output err_segs[15:0]: accumulates corr_cnt per completed operation, saturating.
  - input stats_clr: synchronous clear of both counters. If stats_clr coincides with a completion, the clear wins.
  - Counters update on the DONE handshake edge and reset to 0 on rst.
- When not defined, these ports and registers are absent and the rest of the behaviour is identical.

Test Plan:
- A=16'h0000, B=16'h0000 → SUM=17'h00000, approx_sum=0, corr_cnt=0, err_seen=0, out_valid 2 cycles after accept.
- A=16'hFFFF, B=16'h0001 → SUM=17'h10000, approx_sum=17'h10000, corr_cnt=0, latency 2 (long carry predicted correctly).
- A=16'h003F, B=16'h0000 → approx_sum=17'h0007F, SUM=17'h0003F, corr_cnt=1, err_seen=1, latency 3.
- A=16'h7FFF, B=16'h0000 → approx_sum=17'h0803F, SUM=17'h07FFF, corr_cnt=4, latency 6, segments repaired in order 1,2,3,4 (check SUM after each cycle).
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → outputs stable, in_ready=0, new operands not accepted. Release out_ready → IDLE, then accept.
- Deassert rst during CORRECT of the A=16'h7FFF case → all outputs 0 immediately, in_ready=1 after release, no out_valid. With IADDER_ERR_STATS_EN: err_ops stays 0; after two complete erroneous ops, err_ops=2 and err_segs=5 (for 4+1).

Source files
------------

// File: rtl/iadder_b16_6b_corrector.sv
// Exact-recovery unit for the 16-bit segmented approximate adder (6-bit windows, stride 3).
// Latency: 2 + popcount(mispredicted segments) cycles from accept to out_valid (2..6), one op in flight.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready. IADDER_ERR_STATS_EN adds error counters.
module iadder_b16_6b_corrector #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      A,
  input  logic [15:0]      B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:0]      SUM,
  output logic [16:0]      approx_sum,
  output logic [CNT_W-1:0] corr_cnt,
  output logic             err_seen
`ifdef IADDER_ERR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      err_ops,
  output logic [15:0]      err_segs
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPROX,
    S_CORRECT,
    S_DONE
  } state_t;

  // Bit positions owned by each speculated segment.
  localparam logic [16:0] SEG1_MASK = 17'h001C0;
  localparam logic [16:0] SEG2_MASK = 17'h00E00;
  localparam logic [16:0] SEG3_MASK = 17'h07000;
  localparam logic [16:0] SEG4_MASK = 17'h18000;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [16:0]      r_sum;
  logic [16:0]      r_approx;
  logic [4:1]       r_err;
  logic             r_err_seen;
  logic [CNT_W-1:0] r_corr_cnt;
  logic             r_out_valid;

  logic [16:0]      w_exact;
  logic [16:0]      w_approx;
  logic [4:1]       w_pc;
  logic [4:1]       w_err;
  logic [3:0]       w_lo;
  logic [2:0]       w_hi;
  logic [1:0]       w_top;
  logic [4:1]       w_pick;
  logic [4:1]       w_err_left;
  logic [16:0]      w_mask;
  logic             w_out_hs;

  assign w_exact  = {1'b0, r_a} + {1'b0, r_b};
  assign w_out_hs = (r_state == S_DONE) && r_out_valid && out_ready;

  // Rebuild the approximate sum and flag every segment whose speculated carry-in was wrong.
  // A window's upper 3 bits equal the upper operand bits plus the carry out of its lower 3 bits,
  // so the predicted carry drives both the segment value and the error flag.
  always_comb begin
    w_approx      = '0;
    w_pc          = '0;
    w_err         = '0;
    w_lo          = '0;
    w_hi          = '0;
    w_top         = '0;
    w_approx[5:0] = r_a[5:0] + r_b[5:0];
    for (int k = 1; k <= 4; k++) begin
      w_lo     = {1'b0, r_a[3*k +: 3]} + {1'b0, r_b[3*k +: 3]} + {3'b000, r_a[3*k-3]};
      w_pc[k]  = (w_lo > 4'd7);
      // True carry into bit 3k+3 recovered from the exact sum bit.
      w_err[k] = w_pc[k] ^ (w_exact[3*k+3] ^ r_a[3*k+3] ^ r_b[3*k+3]);
    end
    for (int k = 1; k <= 3; k++) begin
      w_hi                  = r_a[3*k+3 +: 3] + r_b[3*k+3 +: 3] + {2'b00, w_pc[k]};
      w_approx[3*k+3 +: 3]  = w_hi;
    end
    w_top           = {1'b0, r_a[15]} + {1'b0, r_b[15]} + {1'b0, w_pc[4]};
    w_approx[16:15] = w_top;
  end

  // Pick the lowest outstanding error and the sum bits it owns.
  always_comb begin
    w_pick     = r_err & (~r_err + 4'd1);
    w_err_left = r_err & ~w_pick;
    w_mask     = ({17{w_pick[1]}} & SEG1_MASK) |
                 ({17{w_pick[2]}} & SEG2_MASK) |
                 ({17{w_pick[3]}} & SEG3_MASK) |
                 ({17{w_pick[4]}} & SEG4_MASK);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: one approximation cycle, one cycle per repair, then hold until consumed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = S_APPROX;
      S_APPROX:  w_state_nxt = (|w_err) ? S_CORRECT : S_DONE;
      S_CORRECT: if (w_err_left == 4'd0) w_state_nxt = S_DONE;
      S_DONE:    if (w_out_hs) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands, capture the approximation, repair one segment per cycle.
  // out_valid is registered off DONE, so the result appears one cycle after the last repair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_approx    <= '0;
      r_err       <= '0;
      r_err_seen  <= 1'b0;
      r_corr_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= A;
            r_b <= B;
          end
        end
        S_APPROX: begin
          r_approx   <= w_approx;
          r_sum      <= w_approx;
          r_err      <= w_err;
          r_err_seen <= |w_err;
          r_corr_cnt <= '0;
        end
        S_CORRECT: begin
          if (r_err != 4'd0) begin
            r_sum      <= (r_sum & ~w_mask) | (w_exact & w_mask);
            r_err      <= w_err_left;
            r_corr_cnt <= r_corr_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign SUM        = r_sum;
  assign approx_sum = r_approx;
  assign corr_cnt   = r_corr_cnt;
  assign err_seen   = r_err_seen;

`ifdef IADDER_ERR_STATS_EN
  logic [15:0] r_err_ops;
  logic [15:0] r_err_segs;
  logic [16:0] w_segs_sum;

  assign w_segs_sum = {1'b0, r_err_segs} + 17'(r_corr_cnt);

  // Saturating statistics updated on the output handshake; a clear request wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_ops  <= '0;
      r_err_segs <= '0;
    end else if (stats_clr) begin
      r_err_ops  <= '0;
      r_err_segs <= '0;
    end else if (w_out_hs) begin
      if (r_err_seen && (r_err_ops != 16'hFFFF)) begin
        r_err_ops <= r_err_ops + 16'd1;
      end
      r_err_segs <= w_segs_sum[16] ? 16'hFFFF : w_segs_sum[15:0];
    end
  end

  assign err_ops  = r_err_ops;
  assign err_segs = r_err_segs;
`endif

endmodule

// File: tb/tb_iadder_b16_6b_corrector.sv
// Bench for iadder_b16_6b_corrector: directed and random operands, a queue of expected results,
// cycle-accurate latency and per-cycle repair checks, output hold and mid-operation reset.
module tb_iadder_b16_6b_corrector;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [15:0]      A = '0;
  logic [15:0]      B = '0;
  logic             in_ready;
  logic             out_valid;
  logic [16:0]      SUM;
  logic [16:0]      approx_sum;
  logic [CNT_W-1:0] corr_cnt;
  logic             err_seen;
`ifdef IADDER_ERR_STATS_EN
  logic             stats_clr = 1'b0;
  logic [15:0]      err_ops;
  logic [15:0]      err_segs;
`endif

  typedef struct {
    logic [16:0] sum;
    logic [16:0] apx;
    int          cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          c_acc = 0;
  logic [16:0] trace[5] = '{17'h0803F, 17'h081FF, 17'h08FFF, 17'h0FFFF, 17'h07FFF};

  iadder_b16_6b_corrector #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .SUM        (SUM),
    .approx_sum (approx_sum),
    .corr_cnt   (corr_cnt),
    .err_seen   (err_seen)
`ifdef IADDER_ERR_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .err_ops    (err_ops),
    .err_segs   (err_segs)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: windowed approximation and carry-misprediction count, computed with integer shifts.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ia, ib, lo, w, sw, win, pc, tc, m, n, ap;
    ia = int'(a);
    ib = int'(b);
    ap = (ia + ib) & 'h3F;
    n  = 0;
    for (int k = 1; k <= 4; k++) begin
      lo  = 3 * k;
      w   = (k == 4) ? 4 : 6;
      sw  = (k == 4) ? 2 : 3;
      win = ((ia >> lo) & ((1 << w) - 1)) + ((ib >> lo) & ((1 << w) - 1)) + ((ia >> (lo - 3)) & 1);
      ap  = ap | (((win >> 3) & ((1 << sw) - 1)) << (lo + 3));
      pc  = ((((ia >> lo) & 7) + ((ib >> lo) & 7) + ((ia >> (lo - 3)) & 1)) >> 3) & 1;
      m   = (1 << (lo + 3)) - 1;
      tc  = (((ia & m) + (ib & m)) >> (lo + 3)) & 1;
      if (pc != tc) n++;
    end
    e.sum = 17'(ia + ib);
    e.apx = 17'(ap);
    e.cnt = n;
    return e;
  endfunction

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    chk("in_ready_at_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    c_acc    = cyc;
  endtask

  task automatic collect(input string tag);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      last_exp = sb.pop_front();
      chk({tag, "_sum"}, 32'(SUM), 32'(last_exp.sum));
      chk({tag, "_approx"}, 32'(approx_sum), 32'(last_exp.apx));
      chk({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(last_exp.cnt));
      chk({tag, "_err_seen"}, 32'(err_seen), 32'(last_exp.cnt != 0));
      chk({tag, "_latency"}, 32'(cyc - c_acc), 32'(2 + last_exp.cnt));
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        seen;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sum", 32'(SUM), 32'd0);
    chk("rst_approx", 32'(approx_sum), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("rst_err_seen", 32'(err_seen), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    sb.push_back('{17'h00000, 17'h00000, 0});
    accept(16'h0000, 16'h0000);
    collect("zero");
    release_out();

    sb.push_back('{17'h10000, 17'h10000, 0});
    accept(16'hFFFF, 16'h0001);
    collect("ffff_p1");
    release_out();

    sb.push_back('{17'h0003F, 17'h0007F, 1});
    accept(16'h003F, 16'h0000);
    collect("h3f");

    // Hold the result while new operands wait on the input.
    A        = 16'h1234;
    B        = 16'h4321;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(SUM), 32'(last_exp.sum));
      chk("hold_corr_cnt", 32'(corr_cnt), 32'd1);
    end
    release_out();
    sb.push_back(model(16'h1234, 16'h4321));
    accept(16'h1234, 16'h4321);
    collect("after_hold");
    release_out();

    // All four segments mispredicted: repairs land in order 1..4.
    sb.push_back('{17'h07FFF, 17'h0803F, 4});
    accept(16'h7FFF, 16'h0000);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("trace_sum", 32'(SUM), 32'(trace[j]));
      chk("trace_corr_cnt", 32'(corr_cnt), 32'(j));
      chk("trace_out_valid", 32'(out_valid), 32'd0);
    end
    collect("h7fff");
    release_out();

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (i % 4 == 1) rb = 16'h0000;
      sb.push_back(model(ra, rb));
      accept(ra, rb);
      collect("rand");
      release_out();
    end

    // Reset during repair of the 7FFF case: the operation vanishes.
    accept(16'h7FFF, 16'h0000);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(SUM), 32'd0);
    chk("abort_approx", 32'(approx_sum), 32'd0);
    chk("abort_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("abort_err_seen", 32'(err_seen), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", 32'(seen), 32'd0);
`ifdef IADDER_ERR_STATS_EN
    chk("stats_after_abort", 32'(err_ops), 32'd0);
`endif

    sb.push_back('{17'h07FFF, 17'h0803F, 4});
    accept(16'h7FFF, 16'h0000);
    collect("post_rst_h7fff");
    release_out();
    sb.push_back('{17'h0003F, 17'h0007F, 1});
    accept(16'h003F, 16'h0000);
    collect("post_rst_h3f");
    release_out();
`ifdef IADDER_ERR_STATS_EN
    chk("stats_err_ops", 32'(err_ops), 32'd2);
    chk("stats_err_segs", 32'(err_segs), 32'd5);
    sb.push_back('{17'h0003F, 17'h0007F, 1});
    accept(16'h003F, 16'h0000);
    collect("clr_h3f");
    stats_clr = 1'b1;
    release_out();
    stats_clr = 1'b0;
    chk("stats_clr_ops", 32'(err_ops), 32'd0);
    chk("stats_clr_segs", 32'(err_segs), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
